// File: rtl/ubjtag_tap_responder_if.sv
// ---------------------------------------------------------------------------
// ubjtag_tap_responder_if
// Pin bundle between a JTAG host and the ubjtag_tap_responder target.
//   jtag_tck/jtag_tms/jtag_tdi : host -> target JTAG pins (asynchronous)
//   jtag_tdo                   : target -> host, registered
//   in_ready/in_valid/in_data  : Avalon-ST sink, bytes from fabric to host
//   out_ready/out_valid/out_data : Avalon-ST source, bytes from host to fabric
//   overrun                    : sticky flag, a host byte was dropped
//   active                     : TAP is outside Test-Logic-Reset
// master = host/fabric side, slave = responder.
// ---------------------------------------------------------------------------
interface ubjtag_tap_responder_if;
    logic       jtag_tck;
    logic       jtag_tms;
    logic       jtag_tdi;
    logic       jtag_tdo;
    logic       in_ready;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       overrun;
    logic       active;

    modport master (
        output jtag_tck, jtag_tms, jtag_tdi, in_valid, in_data, out_ready,
        input  jtag_tdo, in_ready, out_valid, out_data, overrun, active
    );

    modport slave (
        input  jtag_tck, jtag_tms, jtag_tdi, in_valid, in_data, out_ready,
        output jtag_tdo, in_ready, out_valid, out_data, overrun, active
    );
endinterface

// File: rtl/ubjtag_tap_responder.sv
// ---------------------------------------------------------------------------
// ubjtag_tap_responder
// Target-side JTAG responder. TCK/TMS/TDI are oversampled on the system clock
// and drive an IEEE 1149.1 TAP with a 4-bit IR and three DRs: IDCODE (32b),
// BYPASS (1b) and USER (9b {flag,byte} mailbox exchanging one byte each way
// per DR scan over Avalon-ST).
// Ports:
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : ubjtag_tap_responder_if.slave (JTAG pins, Avalon-ST, status)
// TCK high and low phases must each last at least 4 clock cycles.
// ---------------------------------------------------------------------------
module ubjtag_tap_responder #(
    parameter logic [31:0] IDCODE_VALUE = 32'h0000_0001,
    parameter logic [3:0]  IR_USER      = 4'hC
) (
    input  logic                    clock,
    input  logic                    reset_n,
    ubjtag_tap_responder_if.slave   bus
);
    localparam logic [3:0] IR_IDCODE = 4'h1;

    typedef enum logic [3:0] {
        ST_TLR, ST_RTI, ST_SEL_DR, ST_CAP_DR, ST_SHIFT_DR, ST_EXIT1_DR,
        ST_PAUSE_DR, ST_EXIT2_DR, ST_UPD_DR, ST_SEL_IR, ST_CAP_IR,
        ST_SHIFT_IR, ST_EXIT1_IR, ST_PAUSE_IR, ST_EXIT2_IR, ST_UPD_IR
    } tap_state_t;

    typedef enum logic [1:0] {DR_BYPASS, DR_IDCODE, DR_USER} dr_sel_t;

    logic        tck_meta_r, tck_sync_r, tck_prev_r;
    logic        tms_meta_r, tms_sync_r;
    logic        tdi_meta_r, tdi_sync_r;
    logic        tck_rise_s, tck_fall_s;
    tap_state_t  state_r, next_state_s;
    dr_sel_t     dr_sel_s;
    logic        dr_lsb_s;
    logic [3:0]  ir_r, ir_sr_r;
    logic [31:0] idcode_sr_r;
    logic        bypass_r;
    logic [8:0]  user_sr_r;
    logic        tdo_r, in_ready_r, out_valid_r, overrun_r, active_r;
    logic [7:0]  out_data_r;

    // Two-flop synchronisers on the JTAG pins plus a delayed TCK copy for edge detection.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tck_meta_r <= 1'b0;
            tck_sync_r <= 1'b0;
            tck_prev_r <= 1'b0;
            tms_meta_r <= 1'b0;
            tms_sync_r <= 1'b0;
            tdi_meta_r <= 1'b0;
            tdi_sync_r <= 1'b0;
        end else begin
            tck_meta_r <= bus.jtag_tck;
            tck_sync_r <= tck_meta_r;
            tck_prev_r <= tck_sync_r;
            tms_meta_r <= bus.jtag_tms;
            tms_sync_r <= tms_meta_r;
            tdi_meta_r <= bus.jtag_tdi;
            tdi_sync_r <= tdi_meta_r;
        end
    end

    assign tck_rise_s = tck_sync_r & ~tck_prev_r;
    assign tck_fall_s = ~tck_sync_r & tck_prev_r;

    // Standard 1149.1 TAP transition table driven by the synchronised TMS.
    always_comb begin
        next_state_s = ST_TLR;
        case (state_r)
            ST_TLR:      next_state_s = tms_sync_r ? ST_TLR      : ST_RTI;
            ST_RTI:      next_state_s = tms_sync_r ? ST_SEL_DR   : ST_RTI;
            ST_SEL_DR:   next_state_s = tms_sync_r ? ST_SEL_IR   : ST_CAP_DR;
            ST_CAP_DR:   next_state_s = tms_sync_r ? ST_EXIT1_DR : ST_SHIFT_DR;
            ST_SHIFT_DR: next_state_s = tms_sync_r ? ST_EXIT1_DR : ST_SHIFT_DR;
            ST_EXIT1_DR: next_state_s = tms_sync_r ? ST_UPD_DR   : ST_PAUSE_DR;
            ST_PAUSE_DR: next_state_s = tms_sync_r ? ST_EXIT2_DR : ST_PAUSE_DR;
            ST_EXIT2_DR: next_state_s = tms_sync_r ? ST_UPD_DR   : ST_SHIFT_DR;
            ST_UPD_DR:   next_state_s = tms_sync_r ? ST_SEL_DR   : ST_RTI;
            ST_SEL_IR:   next_state_s = tms_sync_r ? ST_TLR      : ST_CAP_IR;
            ST_CAP_IR:   next_state_s = tms_sync_r ? ST_EXIT1_IR : ST_SHIFT_IR;
            ST_SHIFT_IR: next_state_s = tms_sync_r ? ST_EXIT1_IR : ST_SHIFT_IR;
            ST_EXIT1_IR: next_state_s = tms_sync_r ? ST_UPD_IR   : ST_PAUSE_IR;
            ST_PAUSE_IR: next_state_s = tms_sync_r ? ST_EXIT2_IR : ST_PAUSE_IR;
            ST_EXIT2_IR: next_state_s = tms_sync_r ? ST_UPD_IR   : ST_SHIFT_IR;
            ST_UPD_IR:   next_state_s = tms_sync_r ? ST_SEL_DR   : ST_RTI;
            default:     next_state_s = ST_TLR;
        endcase
    end

    // DR selection from the current IR; any unknown opcode behaves as BYPASS.
    always_comb begin
        if (ir_r == IR_USER) begin
            dr_sel_s = DR_USER;
        end else if (ir_r == IR_IDCODE) begin
            dr_sel_s = DR_IDCODE;
        end else begin
            dr_sel_s = DR_BYPASS;
        end
    end

    // LSB of whichever DR is currently selected, for TDO.
    always_comb begin
        dr_lsb_s = 1'b0;
        case (dr_sel_s)
            DR_USER:   dr_lsb_s = user_sr_r[0];
            DR_IDCODE: dr_lsb_s = idcode_sr_r[0];
            DR_BYPASS: dr_lsb_s = bypass_r;
            default:   dr_lsb_s = 1'b0;
        endcase
    end

    // TAP state, shift registers, mailbox handshakes and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_TLR;
            ir_r        <= IR_IDCODE;
            ir_sr_r     <= 4'b0001;
            idcode_sr_r <= 32'h0000_0000;
            bypass_r    <= 1'b0;
            user_sr_r   <= 9'h000;
            tdo_r       <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= 8'h00;
            overrun_r   <= 1'b0;
            active_r    <= 1'b0;
        end else begin
            in_ready_r <= 1'b0;
            if (out_valid_r && bus.out_ready) begin
                out_valid_r <= 1'b0;
            end
            // in_ready is high in the first clock spent in Capture-DR; the
            // mailbox samples the sink in that same cycle so the load and the
            // handshake refer to identical in_valid/in_data values.
            if (in_ready_r) begin
                user_sr_r <= {bus.in_valid, bus.in_valid ? bus.in_data : 8'h00};
            end
            if (tck_rise_s) begin
                state_r  <= next_state_s;
                active_r <= (next_state_s != ST_TLR);
                case (state_r)
                    ST_SHIFT_IR: ir_sr_r <= {tdi_sync_r, ir_sr_r[3:1]};
                    ST_SHIFT_DR: begin
                        case (dr_sel_s)
                            DR_USER:   user_sr_r   <= {tdi_sync_r, user_sr_r[8:1]};
                            DR_IDCODE: idcode_sr_r <= {tdi_sync_r, idcode_sr_r[31:1]};
                            default:   bypass_r    <= tdi_sync_r;
                        endcase
                    end
                    default: ;
                endcase
                case (next_state_s)
                    ST_TLR: begin
                        ir_r      <= IR_IDCODE;
                        overrun_r <= 1'b0;
                    end
                    ST_CAP_IR: ir_sr_r <= 4'b0001;
                    ST_UPD_IR: ir_r    <= ir_sr_r;
                    ST_CAP_DR: begin
                        case (dr_sel_s)
                            DR_USER:   in_ready_r  <= 1'b1;
                            DR_IDCODE: idcode_sr_r <= IDCODE_VALUE;
                            default:   bypass_r    <= 1'b0;
                        endcase
                    end
                    ST_UPD_DR: begin
                        if (dr_sel_s == DR_USER && user_sr_r[8]) begin
                            // A held byte is replaced only if it leaves in this very cycle.
                            if (!out_valid_r || bus.out_ready) begin
                                out_data_r  <= user_sr_r[7:0];
                                out_valid_r <= 1'b1;
                            end else begin
                                overrun_r <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            if (tck_fall_s) begin
                case (state_r)
                    ST_SHIFT_IR: tdo_r <= ir_sr_r[0];
                    ST_SHIFT_DR: tdo_r <= dr_lsb_s;
                    default:     ;
                endcase
            end
        end
    end

    assign bus.jtag_tdo  = tdo_r;
    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.overrun   = overrun_r;
    assign bus.active    = active_r;
endmodule

// File: tb/tb_ubjtag_tap_responder.sv
// Self-checking bench: directed scenarios followed by randomized scans,
// checked against a scan-level model of the responder.
module tb_ubjtag_tap_responder;
    localparam logic [31:0] IDV  = 32'hDEAD_BEEF;
    localparam logic [3:0]  IR_U = 4'hC;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   total   = 0;
    int   bad     = 0;
    int   rdy_cnt = 0;
    int   hs_cnt  = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    // scan-level model
    logic [3:0] m_ir      = 4'h1;
    logic       m_ov      = 1'b0;
    logic [7:0] m_od      = 8'h00;
    logic       m_overrun = 1'b0;

    ubjtag_tap_responder_if bus();

    ubjtag_tap_responder #(.IDCODE_VALUE(IDV), .IR_USER(IR_U)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    // Observe sink handshakes and bytes delivered on the source.
    always @(posedge clock) begin
        if (reset_n) begin
            if (bus.in_ready) rdy_cnt <= rdy_cnt + 1;
            if (bus.in_ready && bus.in_valid) hs_cnt <= hs_cnt + 1;
            if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic tck(input logic tms, input logic tdi, output logic tdo);
        bus.jtag_tms = tms;
        bus.jtag_tdi = tdi;
        wait_clks(6);
        tdo = bus.jtag_tdo;
        bus.jtag_tck = 1'b1;
        wait_clks(6);
        bus.jtag_tck = 1'b0;
    endtask

    task automatic goto_tlr();
        logic b;
        for (int i = 0; i < 5; i++) tck(1'b1, 1'b0, b);
        m_ir = 4'h1;
        m_overrun = 1'b0;
        tck(1'b0, 1'b0, b);
    endtask

    task automatic scan_ir(input logic [3:0] v, output logic [3:0] o);
        logic b;
        tck(1'b1, 1'b0, b);
        tck(1'b1, 1'b0, b);
        tck(1'b0, 1'b0, b);
        tck(1'b0, 1'b0, b);
        for (int i = 0; i < 4; i++) begin
            tck(i == 3, v[i], b);
            o[i] = b;
        end
        tck(1'b1, 1'b0, b);
        tck(1'b0, 1'b0, b);
        m_ir = v;
    endtask

    task automatic scan_dr(input int n, input logic [63:0] din, output logic [63:0] dout);
        logic b;
        dout = 64'd0;
        tck(1'b1, 1'b0, b);
        tck(1'b0, 1'b0, b);
        tck(1'b0, 1'b0, b);
        for (int i = 0; i < n; i++) begin
            tck(i == n - 1, din[i], b);
            dout[i] = b;
        end
        tck(1'b1, 1'b0, b);
        tck(1'b0, 1'b0, b);
    endtask

    // Bits leaving a DR of length len: captured value first, then TDI delayed by len.
    function automatic logic [63:0] exp_dout(input int n, input logic [63:0] din,
                                             input logic [31:0] cap, input int len);
        logic [63:0] r;
        r = 64'd0;
        for (int i = 0; i < n; i++) begin
            if (i < len) r[i] = cap[i];
            else         r[i] = din[i - len];
        end
        return r;
    endfunction

    task automatic check_state(input string tag);
        check({tag, "_out_valid"}, bus.out_valid, m_ov);
        check({tag, "_out_data"},  bus.out_data,  m_od);
        check({tag, "_overrun"},   bus.overrun,   m_overrun);
        check({tag, "_active"},    bus.active,    1'b1);
    endtask

    task automatic consume(input string tag);
        bus.out_ready = 1'b1;
        wait_clks(1);
        bus.out_ready = 1'b0;
        wait_clks(1);
        if (m_ov) begin
            exp_q.push_back(m_od);
            m_ov = 1'b0;
        end
        check_state(tag);
    endtask

    task automatic do_dr(input int n, input logic [63:0] din, input logic iv,
                         input logic [7:0] idata, input logic ordy, input string tag);
        logic [63:0] dout;
        logic [31:0] cap;
        logic [8:0]  upd;
        int          len, r0, h0;
        logic        user;
        user = (m_ir == IR_U);
        if (user) begin
            len = 9;
            cap = {23'd0, iv, iv ? idata : 8'h00};
        end else if (m_ir == 4'h1) begin
            len = 32;
            cap = IDV;
        end else begin
            len = 1;
            cap = 32'd0;
        end
        bus.in_valid = iv;
        bus.in_data  = idata;
        if (ordy) begin
            bus.out_ready = 1'b1;
            if (m_ov) begin
                exp_q.push_back(m_od);
                m_ov = 1'b0;
            end
        end
        r0 = rdy_cnt;
        h0 = hs_cnt;
        scan_dr(n, din, dout);
        wait_clks(4);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check({tag, "_tdo"}, dout, exp_dout(n, din, cap, len));
        check({tag, "_in_ready_pulses"}, 64'(rdy_cnt - r0), user ? 64'd1 : 64'd0);
        check({tag, "_handshakes"}, 64'(hs_cnt - h0), (user && iv) ? 64'd1 : 64'd0);
        if (user) begin
            upd = din[n - 9 +: 9];
            if (upd[8]) begin
                if (ordy) begin
                    m_od = upd[7:0];
                    exp_q.push_back(m_od);
                end else if (!m_ov) begin
                    m_ov = 1'b1;
                    m_od = upd[7:0];
                end else begin
                    m_overrun = 1'b1;
                end
            end
        end
        check_state(tag);
    endtask

    initial begin
        logic [3:0]  ir_o;
        logic [3:0]  v;
        logic        b;
        int          op, n;
        bus.jtag_tck  = 1'b0;
        bus.jtag_tms  = 1'b1;
        bus.jtag_tdi  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;

        // T1 reset values and TLR behaviour
        wait_clks(5);
        check("rst_tdo", bus.jtag_tdo, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data", bus.out_data, 8'h00);
        check("rst_overrun", bus.overrun, 1'b0);
        check("rst_active", bus.active, 1'b0);
        reset_n = 1'b1;
        wait_clks(3);
        for (int i = 0; i < 5; i++) tck(1'b1, 1'b0, b);
        check("tlr_active", bus.active, 1'b0);
        tck(1'b0, 1'b0, b);
        check("rti_active", bus.active, 1'b1);

        // T2 IDCODE after reset
        do_dr(32, {$urandom, $urandom}, 1'b0, 8'h00, 1'b0, "t2_idcode");

        // T3 BYPASS via IR=F
        scan_ir(4'hF, ir_o);
        check("t3_ir_capture", ir_o, 4'b0001);
        do_dr(8, 64'hB2, 1'b0, 8'h00, 1'b0, "t3_bypass");

        // T4 host writes, second one overruns
        scan_ir(IR_U, ir_o);
        check("t4_ir_capture", ir_o, 4'b0001);
        do_dr(9, 64'h1A5, 1'b0, 8'h00, 1'b0, "t4_write1");
        do_dr(9, 64'h15A, 1'b0, 8'h00, 1'b0, "t4_write2");
        consume("t4_consume");

        // T5 host reads
        do_dr(9, 64'h000, 1'b1, 8'h3C, 1'b0, "t5_read1");
        do_dr(9, 64'h000, 1'b0, 8'h77, 1'b0, "t5_read2");

        // randomized mix of IR scans, DR scans, consumes and TAP resets
        for (int it = 0; it < 16; it++) begin
            op = $urandom_range(0, 5);
            case (op)
                0: begin
                    v = ($urandom_range(0, 1) == 1) ? IR_U : 4'($urandom);
                    scan_ir(v, ir_o);
                    check("rnd_ir_capture", ir_o, 4'b0001);
                end
                4: consume("rnd_consume");
                5: begin
                    goto_tlr();
                    check_state("rnd_tlr");
                end
                default: begin
                    n = (m_ir == IR_U) ? 9 + $urandom_range(0, 7) : $urandom_range(1, 40);
                    do_dr(n, {$urandom, $urandom}, 1'($urandom), 8'($urandom),
                          1'($urandom), "rnd_dr");
                end
            endcase
        end

        // T6 reset_n mid Shift-DR
        consume("t6_pre");
        scan_ir(IR_U, ir_o);
        tck(1'b1, 1'b0, b);
        tck(1'b0, 1'b0, b);
        tck(1'b0, 1'b0, b);
        for (int i = 0; i < 4; i++) tck(1'b0, 1'b1, b);
        wait_clks(2);
        reset_n = 1'b0;
        wait_clks(3);
        m_ir = 4'h1;
        m_ov = 1'b0;
        m_od = 8'h00;
        m_overrun = 1'b0;
        check("t6_tdo", bus.jtag_tdo, 1'b0);
        check("t6_out_valid", bus.out_valid, 1'b0);
        check("t6_out_data", bus.out_data, 8'h00);
        check("t6_overrun", bus.overrun, 1'b0);
        check("t6_active", bus.active, 1'b0);
        reset_n = 1'b1;
        wait_clks(3);
        tck(1'b0, 1'b0, b);
        check_state("t6_rti");
        do_dr(32, {$urandom, $urandom}, 1'b0, 8'h00, 1'b0, "t6_idcode");

        // bytes delivered to fabric in order
        check("delivered_count", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check("delivered_byte", got_q[i], exp_q[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
